burst_clock_divider: RTL and testbench



---
 rtl/burst_clock_divider.sv | 179 +++++++++++++++++
 tb/tb_burst_clock_divider.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_clock_divider.sv
// burst_clock_divider
//   Runtime-programmable divided-clock generator. Produces clock_out with
//   hp cycles high and hp cycles low per period. In burst mode it runs
//   pulse_count periods and stops. With pulse_count == 0 it runs until a
//   stop request arrives. The generator never truncates a period.
//
// Ports
//   clock        system clock, all logic on the rising edge
//   reset        synchronous, active-high reset
//   start        begin a run (accepted only while idle)
//   stop         graceful stop request (latched only while busy)
//   half_period  cycles per half period, 0 treated as 1 (latched at start)
//   pulse_count  periods per burst, 0 = continuous (latched at start)
//   clock_out    divided clock (registered)
//   rise_strobe  high in the first high cycle of each period
//   fall_strobe  high in the first low cycle of each period
//   busy         run in progress
//   done         one-cycle pulse after the final low phase
//   pulses_done  completed periods in the current or last run
//   state_dbg    current FSM state (0 idle, 1 high, 2 low)
//
// Handshake: start behaves like 'valid' and the idle state behaves like
// 'ready'. A start is taken at any edge where the FSM is idle and start is
// high. That edge is the only point where half_period and pulse_count are
// sampled. busy is high from the next cycle until done is pulsed, and done
// coincides with the first idle cycle. A start held high during done is
// therefore accepted at once.
module burst_clock_divider #(
    parameter int CNT_W   = 8,
    parameter int PULSE_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [CNT_W-1:0]   half_period,
    input  logic [PULSE_W-1:0] pulse_count,
    output logic               clock_out,
    output logic               rise_strobe,
    output logic               fall_strobe,
    output logic               busy,
    output logic               done,
    output logic [PULSE_W-1:0] pulses_done,
    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   phase_q, phase_d;
    logic [CNT_W-1:0]   hp_q, hp_d;
    logic [PULSE_W-1:0] n_q, n_d;
    logic               stop_pending_q, stop_pending_d;
    logic               clock_out_d, rise_d, fall_d, busy_d, done_d;
    logic [PULSE_W-1:0] pulses_d;
    logic [PULSE_W-1:0] pd_inc;
    logic               phase_end;
    logic               period_last;

    assign phase_end = (phase_q == hp_q);
    assign pd_inc    = pulses_done + PULSE_W'(1);
    // The period that is completing now is the final one. This holds when the
    // burst count is reached or when a stop was latched during the run.
    assign period_last = phase_end &&
                         (((n_q != '0) && (pd_inc == n_q)) || stop_pending_q);
    assign state_dbg = state_q;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_HIGH;
            S_HIGH: if (phase_end) state_d = S_LOW;
            S_LOW:  if (phase_end) state_d = period_last ? S_IDLE : S_HIGH;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values (registered below)
    always_comb begin
        clock_out_d    = clock_out;
        rise_d         = 1'b0;
        fall_d         = 1'b0;
        busy_d         = busy;
        done_d         = 1'b0;
        pulses_d       = pulses_done;
        phase_d        = phase_q;
        hp_d           = hp_q;
        n_d            = n_q;
        stop_pending_d = stop_pending_q;
        case (state_q)
            S_IDLE: begin
                clock_out_d    = 1'b0;
                busy_d         = 1'b0;
                stop_pending_d = 1'b0;
                if (start) begin
                    hp_d        = (half_period == '0) ? CNT_W'(1) : half_period;
                    n_d         = pulse_count;
                    pulses_d    = '0;
                    clock_out_d = 1'b1;
                    rise_d      = 1'b1;
                    busy_d      = 1'b1;
                    phase_d     = CNT_W'(1);
                end
            end
            S_HIGH: begin
                if (stop) stop_pending_d = 1'b1;
                if (phase_end) begin
                    clock_out_d = 1'b0;
                    fall_d      = 1'b1;
                    phase_d     = CNT_W'(1);
                end else begin
                    phase_d = phase_q + CNT_W'(1);
                end
            end
            S_LOW: begin
                if (stop) stop_pending_d = 1'b1;
                if (phase_end) begin
                    pulses_d = pd_inc;
                    if (period_last) begin
                        done_d         = 1'b1;
                        busy_d         = 1'b0;
                        stop_pending_d = 1'b0;
                    end else begin
                        clock_out_d = 1'b1;
                        rise_d      = 1'b1;
                        phase_d     = CNT_W'(1);
                    end
                end else begin
                    phase_d = phase_q + CNT_W'(1);
                end
            end
            default: begin
                clock_out_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            clock_out      <= 1'b0;
            rise_strobe    <= 1'b0;
            fall_strobe    <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pulses_done    <= '0;
            phase_q        <= '0;
            hp_q           <= '0;
            n_q            <= '0;
            stop_pending_q <= 1'b0;
        end else begin
            clock_out      <= clock_out_d;
            rise_strobe    <= rise_d;
            fall_strobe    <= fall_d;
            busy           <= busy_d;
            done           <= done_d;
            pulses_done    <= pulses_d;
            phase_q        <= phase_d;
            hp_q           <= hp_d;
            n_q            <= n_d;
            stop_pending_q <= stop_pending_d;
        end
    end

endmodule

// File: tb/tb_burst_clock_divider.sv
module tb_burst_clock_divider;

    localparam int CNT_W   = 8;
    localparam int PULSE_W = 8;
    localparam int EW      = 5 + PULSE_W;
    localparam longint BIG = longint'(1) << 30;

    // ---------------- clock / reset block ----------------
    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic               stop  = 1'b0;
    logic [CNT_W-1:0]   half_period = '0;
    logic [PULSE_W-1:0] pulse_count = '0;
    logic               clock_out, rise_strobe, fall_strobe, busy, done;
    logic [PULSE_W-1:0] pulses_done;
    logic [1:0]         state_dbg;

    always #5 clock = ~clock;

    burst_clock_divider #(.CNT_W(CNT_W), .PULSE_W(PULSE_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .half_period (half_period),
        .pulse_count (pulse_count),
        .clock_out   (clock_out),
        .rise_strobe (rise_strobe),
        .fall_strobe (fall_strobe),
        .busy        (busy),
        .done        (done),
        .pulses_done (pulses_done),
        .state_dbg   (state_dbg)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    // The run is described by its start edge t0, half period hp and the
    // number of periods it will last (term). Outputs in any cycle follow from
    // the elapsed time since t0 by plain division and remainder.
    logic [EW-1:0] exp_q[$];
    longint gcyc = 0;
    bit     m_active = 1'b0;
    longint m_t0 = 0, m_hp = 1, m_term = BIG;
    logic [PULSE_W-1:0] m_pd = '0;

    task automatic model_step();
        logic e_clk, e_rise, e_fall, e_busy, e_done;
        longint k, r, p, m;
        e_clk = 0; e_rise = 0; e_fall = 0; e_busy = 0; e_done = 0;
        if (reset) begin
            m_active = 1'b0;
            m_pd     = '0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1'b1;
                m_t0     = gcyc;
                m_hp     = (half_period == 0) ? 1 : longint'(half_period);
                m_term   = (pulse_count == 0) ? BIG : longint'(pulse_count);
                m_pd     = '0;
                e_clk = 1; e_rise = 1; e_busy = 1;
            end
        end else begin
            if (stop) begin
                m = (gcyc - m_t0) / (2 * m_hp) + 1;
                if (m < m_term) m_term = m;
            end
            k = gcyc + 1 - m_t0;
            if (k == 2 * m_hp * m_term + 1) begin
                e_done   = 1;
                m_pd     = PULSE_W'(m_term);
                m_active = 1'b0;
            end else begin
                r = (k - 1) % (2 * m_hp);
                p = (k - 1) / (2 * m_hp);
                e_clk  = (r < m_hp);
                e_rise = (r == 0);
                e_fall = (r == m_hp);
                e_busy = 1;
                m_pd   = PULSE_W'(p);
            end
        end
        exp_q.push_back({e_clk, e_rise, e_fall, e_busy, e_done, m_pd});
        gcyc++;
    endtask

    task automatic compare();
        logic [EW-1:0] e;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check("clock_out",   clock_out,   e[EW-1]);
            check("rise_strobe", rise_strobe, e[EW-2]);
            check("fall_strobe", fall_strobe, e[EW-3]);
            check("busy",        busy,        e[EW-4]);
            check("done",        done,        e[EW-5]);
            check("pulses_done", pulses_done, e[PULSE_W-1:0]);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        compare();
    endtask

    typedef struct {
        int hp;
        int n;
        int stop_at;
        int poke_at;
        int exp_done;
        int exp_pulses;
        int exp_edges;
    } scen_t;

    // Starts a run at relative edge 0, observes cycles 1.. until done.
    task automatic run_scenario(input scen_t s, input string tag);
        int rises, falls, done_cyc;
        start = 0; stop = 1; tick();   // stop while idle must be ignored
        stop = 0; tick();
        half_period = CNT_W'(s.hp); pulse_count = PULSE_W'(s.n); start = 1;
        tick();
        start = 0;
        half_period = CNT_W'($urandom);  // must not affect the running burst
        pulse_count = PULSE_W'($urandom);
        rises = 0; falls = 0; done_cyc = -1;
        for (int c = 1; c <= 2000; c++) begin
            if (done) begin
                done_cyc = c;
                break;
            end
            if (rise_strobe) rises++;
            if (fall_strobe) falls++;
            stop  = (c == s.stop_at);
            start = (c == s.poke_at);
            tick();
        end
        stop = 0; start = 0;
        check({tag, "_done_cycle"}, done_cyc, s.exp_done);
        check({tag, "_pulses"}, pulses_done, s.exp_pulses);
        check({tag, "_rises"}, rises, s.exp_edges);
        check({tag, "_falls"}, falls, s.exp_edges);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        scen_t tbl[8];
        logic [0:16] pat;
        int dones;

        tbl[0] = '{3,   4, -1, -1, 25,  4, 4};  // basic burst
        tbl[1] = '{0,   2, -1, -1, 5,   2, 2};  // hp 0 acts as 1
        tbl[2] = '{2,   0,  9, -1, 13,  3, 3};  // continuous, stop mid-high
        tbl[3] = '{2,   3, -1,  5, 13,  3, 3};  // start while busy ignored
        tbl[4] = '{2,   3, 12, -1, 13,  3, 3};  // stop at natural completion
        tbl[5] = '{1,   0,  4, -1, 7,   3, 3};  // divide-by-2 continuous
        tbl[6] = '{255, 1, -1, -1, 511, 1, 1};  // maximum half period
        tbl[7] = '{5,   2, -1,  3, 21,  2, 2};

        // reset state
        reset = 1;
        repeat (3) tick();
        check("reset_clock_out", clock_out, 0);
        check("reset_busy", busy, 0);
        check("reset_pulses", pulses_done, 0);
        reset = 0;
        tick();

        for (int i = 0; i < 8; i++) run_scenario(tbl[i], $sformatf("scen%0d", i));

        // back-to-back runs with start held; half_period changed mid-run
        repeat (3) tick();
        pat = 17'b10010011111000000;
        dones = 0;
        half_period = 1; pulse_count = 1; start = 1;
        tick();
        for (int c = 1; c <= 17; c++) begin
            check($sformatf("b2b_clk_c%0d", c), clock_out, pat[c-1]);
            if (done) dones++;
            if (c == 4) half_period = 5;
            if (c == 7) start = 0;
            tick();
        end
        check("b2b_dones", dones, 3);
        check("b2b_pulses", pulses_done, 1);

        // reset in the middle of a run
        repeat (2) tick();
        half_period = 4; pulse_count = 3; start = 1;
        tick();
        start = 0;
        for (int c = 1; c <= 5; c++) begin
            if (c == 5) reset = 1;
            tick();
        end
        reset = 0;
        check("midreset_clock_out", clock_out, 0);
        check("midreset_busy", busy, 0);
        check("midreset_pulses", pulses_done, 0);
        dones = 0;
        for (int c = 6; c <= 45; c++) begin
            if (done) dones++;
            tick();
        end
        check("midreset_no_done", dones, 0);
        run_scenario('{4, 3, -1, -1, 25, 3, 3}, "after_reset");

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 299) == 0);
            start       = ($urandom_range(0, 3) == 0);
            stop        = ($urandom_range(0, 24) == 0);
            half_period = CNT_W'($urandom_range(0, 5));
            pulse_count = PULSE_W'($urandom_range(0, 4));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
